// File: rtl/uc_multiciclo_pkg.sv
// Shared types for the multi-cycle control unit: state encoding, opcode map
// and the control word driven into the datapath.
package uc_multiciclo_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] CLS_ALU_RR  = 2'b00;
  localparam logic [1:0] CLS_ALU_IMM = 2'b01;

  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_JZ   = 6'b100001;
  localparam logic [5:0] OP_JNZ  = 6'b100010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] alu_op;
    logic       pc_we;
  } ctrl_t;

  // Values held outside EXEC: nothing written, PC path selects PC+1.
  localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0, wez: 1'b0,
                                  alu_op: 3'b000, pc_we: 1'b0};
  // Baseline in EXEC: a NOP that still advances the PC.
  localparam ctrl_t CTRL_NOP  = '{s_inc: 1'b1, s_inm: 1'b0, we: 1'b0, wez: 1'b0,
                                  alu_op: 3'b000, pc_we: 1'b1};

endpackage

// File: rtl/uc_multiciclo_if.sv
// Datapath-facing bundle: opcode/zero flow into the control unit, control
// strobes flow out. No handshake: opcode and zero are sampled only in EXEC.
interface uc_multiciclo_if;
  logic [5:0] opcode;
  logic       zero;
  logic       s_inc;
  logic       s_inm;
  logic       we;
  logic       wez;
  logic [2:0] ALUOp;
  logic       pc_we;

  modport master (input opcode, zero,
                  output s_inc, s_inm, we, wez, ALUOp, pc_we);
  modport slave  (output opcode, zero,
                  input s_inc, s_inm, we, wez, ALUOp, pc_we);
endinterface

// File: rtl/uc_multiciclo_decoder.sv
// Pure combinational opcode decode; the caller gates the result to EXEC.
module uc_multiciclo_decoder
  import uc_multiciclo_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       zero,
  output ctrl_t      ctrl,
  output logic       illegal_hit
);

  always_comb begin
    ctrl        = CTRL_NOP;
    illegal_hit = 1'b0;
    case (opcode[5:4])
      CLS_ALU_RR: begin
        ctrl.we     = 1'b1;
        ctrl.wez    = 1'b1;
        ctrl.alu_op = opcode[2:0];
      end
      CLS_ALU_IMM: begin
        ctrl.we     = 1'b1;
        ctrl.wez    = 1'b1;
        ctrl.s_inm  = 1'b1;
        ctrl.alu_op = opcode[2:0];
      end
      default: begin
        // Jump class: zero is the flag left by the previous ALU instruction.
        case (opcode)
          OP_J:    ctrl.s_inc = 1'b0;
          OP_JZ:   ctrl.s_inc = ~zero;
          OP_JNZ:  ctrl.s_inc = zero;
          OP_HALT: ctrl.s_inc = 1'b1;
          default: illegal_hit = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit: IDLE/FETCH/EXEC/HALT sequencer with single-step,
// sticky illegal-opcode flag and a saturating retired-instruction counter.
module uc_multiciclo
  import uc_multiciclo_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  uc_multiciclo_if.master    dp,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count,
  output logic [1:0]         state_dbg
);

  state_t state, state_nxt;
  ctrl_t  dec_ctrl, ctrl;
  logic   illegal_hit;

  uc_multiciclo_decoder u_decoder (
    .opcode      (dp.opcode),
    .zero        (dp.zero),
    .ctrl        (dec_ctrl),
    .illegal_hit (illegal_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_EXEC) begin
        if (illegal_hit) illegal <= 1'b1;
        if (instr_count != '1) instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      // Program memory needs one cycle; step mode stretches FETCH until step.
      S_FETCH: if (!step_mode || step) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (dp.opcode == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:  if (start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ctrl     = (state == S_EXEC) ? dec_ctrl : CTRL_IDLE;
  assign dp.s_inc = ctrl.s_inc;
  assign dp.s_inm = ctrl.s_inm;
  assign dp.we    = ctrl.we;
  assign dp.wez   = ctrl.wez;
  assign dp.ALUOp = ctrl.alu_op;
  assign dp.pc_we = ctrl.pc_we;

  assign busy      = (state == S_FETCH) || (state == S_EXEC);
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

endmodule
